// File: rtl/led_frame_arbiter.sv
// Double-buffered 16x16 red/green frame store for the LED array. Two row writers
// share the back buffer through a round-robin arbiter; swap presents it and optionally clears the new back buffer.
module led_frame_arbiter #(
  parameter bit          CLR_ON_SWAP = 1'b1,
  parameter int unsigned ROWS        = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0_valid,
  input  logic [3:0]           req0_row,
  input  logic [15:0]          req0_red,
  input  logic [15:0]          req0_green,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [3:0]           req1_row,
  input  logic [15:0]          req1_red,
  input  logic [15:0]          req1_green,
  output logic                 req1_ready,
  input  logic                 swap_req,
  output logic                 busy,
  output logic                 frame_done,
  output logic [7:0]           frame_count,
  output logic [ROWS*16-1:0]   disp_red,
  output logic [ROWS*16-1:0]   disp_green
);

  localparam int unsigned ROW_W = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned BUF_W = ROWS * ROW_W;

  localparam logic [1:0] ST_ACCEPT = 2'd0;
  localparam logic [1:0] ST_SWAP   = 2'd1;
  localparam logic [1:0] ST_CLEAR  = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             swap_pending;
  logic             pending_next;
  logic             last_grant;
  logic             grant0_c;
  logic             grant1_c;
  logic [IDX_W-1:0] clr_row;
  logic [BUF_W-1:0] back_red;
  logic [BUF_W-1:0] back_green;

  // Next state, swap-pending tracking and round-robin grant.
  always_comb begin
    state_next   = state;
    pending_next = swap_pending;
    grant0_c     = 1'b0;
    grant1_c     = 1'b0;
    case (state)
      ST_ACCEPT: begin
        if (swap_req || swap_pending) begin
          state_next   = ST_SWAP;
          pending_next = 1'b0;
        end else begin
          grant0_c = req0_valid && (!req1_valid || last_grant);
          grant1_c = req1_valid && (!req0_valid || !last_grant);
        end
      end
      ST_SWAP: begin
        if (swap_req) pending_next = 1'b1;
        state_next = CLR_ON_SWAP ? ST_CLEAR : ST_ACCEPT;
      end
      ST_CLEAR: begin
        if (swap_req) pending_next = 1'b1;
        if (clr_row == IDX_W'(ROWS - 1)) state_next = ST_ACCEPT;
      end
      default: state_next = ST_ACCEPT;
    endcase
  end

  assign req0_ready = grant0_c;
  assign req1_ready = grant1_c;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= ST_ACCEPT;
      swap_pending <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_next;
      swap_pending <= pending_next;
      busy         <= (state_next != ST_ACCEPT) || pending_next;
    end
  end

  // Frame storage: disp_* hold the front buffer, so a swap exchanges contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      back_red    <= '0;
      back_green  <= '0;
      disp_red    <= '0;
      disp_green  <= '0;
      last_grant  <= 1'b1;
      clr_row     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_done <= 1'b0;
      if (grant0_c) begin
        back_red[ROW_W*req0_row +: ROW_W]   <= req0_red;
        back_green[ROW_W*req0_row +: ROW_W] <= req0_green;
        last_grant <= 1'b0;
      end else if (grant1_c) begin
        back_red[ROW_W*req1_row +: ROW_W]   <= req1_red;
        back_green[ROW_W*req1_row +: ROW_W] <= req1_green;
        last_grant <= 1'b1;
      end
      if (state == ST_SWAP) begin
        disp_red    <= back_red;
        disp_green  <= back_green;
        back_red    <= disp_red;
        back_green  <= disp_green;
        frame_done  <= 1'b1;
        frame_count <= frame_count + 8'd1;
        clr_row     <= '0;
      end
      if (state == ST_CLEAR) begin
        back_red[ROW_W*clr_row +: ROW_W]   <= '0;
        back_green[ROW_W*clr_row +: ROW_W] <= '0;
        clr_row <= clr_row + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: arbitration, swap/clear timing,
// pending-swap handling, reset mid-clear and frame counter wrap.
module tb_led_frame_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         req0_valid = 1'b0;
  logic [3:0]   req0_row = '0;
  logic [15:0]  req0_red = '0;
  logic [15:0]  req0_green = '0;
  logic         req0_ready;
  logic         req1_valid = 1'b0;
  logic [3:0]   req1_row = '0;
  logic [15:0]  req1_red = '0;
  logic [15:0]  req1_green = '0;
  logic         req1_ready;
  logic         swap_req = 1'b0;
  logic         busy;
  logic         frame_done;
  logic [7:0]   frame_count;
  logic [255:0] disp_red;
  logic [255:0] disp_green;

  int vectors = 0;
  int miscompares = 0;
  int fd_count = 0;

  led_frame_arbiter #(.CLR_ON_SWAP(1'b1), .ROWS(16)) dut (
    .CLK(CLK), .RST(RST),
    .req0_valid(req0_valid), .req0_row(req0_row), .req0_red(req0_red),
    .req0_green(req0_green), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_row(req1_row), .req1_red(req1_red),
    .req1_green(req1_green), .req1_ready(req1_ready),
    .swap_req(swap_req), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .disp_red(disp_red), .disp_green(disp_green)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_done === 1'b1) fd_count++;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    swap_req = 1'b0;
    tick();
    tick();
    RST = 1'b0;
  endtask

  task automatic wr(input int port, input logic [3:0] row, input logic [15:0] r, input logic [15:0] g);
    int n;
    n = 0;
    if (port == 0) begin
      req0_valid = 1'b1; req0_row = row; req0_red = r; req0_green = g;
    end else begin
      req1_valid = 1'b1; req1_row = row; req1_red = r; req1_green = g;
    end
    #1;
    while (((port == 0) ? req0_ready : req1_ready) !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) chk("wr_timeout", 256'(n), 256'(0));
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic swap();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) chk("idle_timeout", 256'(n), 256'(0));
  endtask

  initial begin
    int n;
    int r0;
    int r1;
    int fd_base;
    logic exp0;

    // 1: reset values, single write, swap latency
    do_reset();
    chk("rst_disp_red", disp_red, '0);
    chk("rst_disp_green", disp_green, '0);
    chk("rst_frame_count", 256'(frame_count), 256'(0));
    chk("rst_frame_done", 256'(frame_done), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    wr(0, 4'd3, 16'hA5A5, 16'h0F0F);
    chk("write_no_display", disp_red, '0);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("swap_state_busy", 256'(busy), 256'(1));
    chk("swap_state_disp", disp_red, '0);
    req1_valid = 1'b1;
    #1;
    chk("swap_state_ready", 256'(req1_ready), 256'(0));
    req1_valid = 1'b0;
    tick();
    chk("t1_red_row3", 256'(disp_red[63:48]), 256'(16'hA5A5));
    chk("t1_green_row3", 256'(disp_green[63:48]), 256'(16'h0F0F));
    chk("t1_frame_done", 256'(frame_done), 256'(1));
    chk("t1_frame_count", 256'(frame_count), 256'(1));
    tick();
    chk("t1_frame_done_low", 256'(frame_done), 256'(0));
    wait_idle(n);

    // 2: round-robin alternation, then same-row later-write-wins
    do_reset();
    r0 = 0;
    r1 = 1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req0_row = 4'(r0); req0_red = 16'hC000 | 16'(r0); req0_green = 16'h0300 | 16'(r0 << 4);
      req1_row = 4'(r1); req1_red = 16'hC000 | 16'(r1); req1_green = 16'h0300 | 16'(r1 << 4);
      #1;
      exp0 = (i % 2 == 0);
      chk($sformatf("rr_ready0_%0d", i), 256'(req0_ready), 256'(exp0));
      chk($sformatf("rr_ready1_%0d", i), 256'(req1_ready), 256'(!exp0));
      tick();
      if (exp0) r0 += 2; else r1 += 2;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wr(0, 4'd7, 16'h1111, 16'h2222);
    wr(1, 4'd7, 16'h3333, 16'h4444);
    swap();
    wait_idle(n);
    for (int r = 0; r < 6; r++) begin
      chk($sformatf("rr_red_row%0d", r), 256'(disp_red[16*r +: 16]), 256'(16'hC000 | 16'(r)));
      chk($sformatf("rr_green_row%0d", r), 256'(disp_green[16*r +: 16]), 256'(16'h0300 | 16'(r << 4)));
    end
    chk("rr_row6_empty", 256'(disp_red[111:96]), 256'(0));
    chk("later_write_red", 256'(disp_red[127:112]), 256'(16'h3333));
    chk("later_write_green", 256'(disp_green[127:112]), 256'(16'h4444));

    // 3: auto-clear after swap, busy duration
    do_reset();
    for (int r = 0; r < 16; r++) wr(0, 4'(r), 16'hFFFF, 16'hFFFF);
    swap();
    wait_idle(n);
    chk("clr_busy_cycles_1", 256'(n), 256'(17));
    chk("full_red", disp_red, {256{1'b1}});
    chk("full_green", disp_green, {256{1'b1}});
    swap();
    wait_idle(n);
    chk("clr_busy_cycles_2", 256'(n), 256'(17));
    chk("cleared_red", disp_red, '0);
    chk("cleared_green", disp_green, '0);
    chk("clr_frame_count", 256'(frame_count), 256'(2));

    // 4: swap requests during CLEAR collapse into one pending swap
    do_reset();
    fd_base = fd_count;
    swap();
    n = 0;
    while (busy !== 1'b0 && n < 80) begin
      n++;
      swap_req = (n == 7 || n == 11);
      tick();
      swap_req = 1'b0;
    end
    chk("pend_busy_cycles", 256'(n), 256'(35));
    chk("pend_frame_count", 256'(frame_count), 256'(2));
    chk("pend_frame_done_pulses", 256'(fd_count - fd_base), 256'(2));

    // 5: reset in the middle of CLEAR, with a swap pending
    do_reset();
    wr(0, 4'd0, 16'hFFFF, 16'hFFFF);
    swap();
    for (int i = 0; i < 9; i++) begin
      swap_req = (i == 4);
      tick();
      swap_req = 1'b0;
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("midclr_disp_red", disp_red, '0);
    chk("midclr_disp_green", disp_green, '0);
    chk("midclr_frame_count", 256'(frame_count), 256'(0));
    chk("midclr_busy", 256'(busy), 256'(0));
    chk("midclr_frame_done", 256'(frame_done), 256'(0));
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("midclr_ready0", 256'(req0_ready), 256'(1));
    chk("midclr_ready1", 256'(req1_ready), 256'(0));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    chk("midclr_still_idle", 256'(busy), 256'(0));

    // 6: frame counter wrap
    do_reset();
    fd_base = fd_count;
    for (int i = 0; i < 256; i++) begin
      swap();
      wait_idle(n);
      if (i == 254) chk("wrap_count_255", 256'(frame_count), 256'(255));
    end
    chk("wrap_count_0", 256'(frame_count), 256'(0));
    chk("wrap_frame_done_pulses", 256'(fd_count - fd_base), 256'(256));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
